// File: rtl/dig_display.sv
// dig_display: eight-digit multiplexed seven-segment driver.
// A 32-bit data register (one hex nibble per digit) is written over a simple
// address-decoded bus. A free-running scan counter dwells SCAN_DIV cycles on
// each digit; digit-select and segment outputs are registered, active-low.
module dig_display #(
  parameter int unsigned SCAN_DIV = 20000,
  parameter logic [31:0] DIG_ADDR = 32'hFFFF_F000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  // Last count value before the dwell counter wraps to zero.
  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 32'd1);

  // Hex nibble to active-low segment pattern {dp,g,f,e,d,c,b,a}; dp stays off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0:    pat = 8'hC0;
      4'h1:    pat = 8'hF9;
      4'h2:    pat = 8'hA4;
      4'h3:    pat = 8'hB0;
      4'h4:    pat = 8'h99;
      4'h5:    pat = 8'h92;
      4'h6:    pat = 8'h82;
      4'h7:    pat = 8'hF8;
      4'h8:    pat = 8'h80;
      4'h9:    pat = 8'h90;
      4'hA:    pat = 8'h88;
      4'hB:    pat = 8'h83;
      4'hC:    pat = 8'hC6;
      4'hD:    pat = 8'hA1;
      4'hE:    pat = 8'h86;
      4'hF:    pat = 8'h8E;
      default: pat = 8'hFF;
    endcase
    return pat;
  endfunction

  logic [31:0] data_r;
  logic [15:0] cnt_r;
  logic [2:0]  idx_r;
  logic        wrap_s;
  logic        wr_s;
  logic [3:0]  nib_s;

  assign wrap_s = (cnt_r == CNT_LAST);
  assign wr_s   = we && (addr == DIG_ADDR);
  assign nib_s  = data_r[{idx_r, 2'b00} +: 4];

  // Capture display data on an address-matched write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= 32'h0000_0000;
    end else if (wr_s) begin
      data_r <= wdata;
    end else begin
      data_r <= data_r;
    end
  end

  // Dwell counter and digit index; the index steps only when the dwell wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'd0;
      idx_r <= 3'd0;
    end else if (wrap_s) begin
      cnt_r <= 16'd0;
      idx_r <= idx_r + 3'd1;
    end else begin
      cnt_r <= cnt_r + 16'd1;
      idx_r <= idx_r;
    end
  end

  // Registered outputs, one cycle behind the current index and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_en <= 8'hFF;
      seg    <= 8'hFF;
    end else begin
      dig_en <= ~(8'b0000_0001 << idx_r);
      seg    <= hex_to_seg(nib_s);
    end
  end

endmodule

// File: tb/tb_dig_display.sv
// tb_dig_display: randomized scoreboard bench for dig_display (SCAN_DIV=4).
// A reference model derives each output edge from the edge count since reset
// and the data value seen so far; a monitor pops and compares every cycle.
module tb_dig_display;

  localparam int unsigned S  = 4;
  localparam logic [31:0] DA = 32'hFFFF_F000;

  typedef struct packed {
    logic [7:0] dig;
    logic [7:0] sg;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        we    = 1'b0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [7:0]  dig_en;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  exp_t        q[$];
  int unsigned n_edge = 0;
  logic [31:0] m_data = 32'h0;

  dig_display #(.SCAN_DIV(S), .DIG_ADDR(DA)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .wdata(wdata),
    .dig_en(dig_en), .seg(seg)
  );

  // Free-running clock, posedges at 5,15,25...
  always #5 clk = ~clk;

  // Reference model: output at edge n after reset shows digit ((n-1)/S) mod 8
  // using the data written on edges before n.
  always @(posedge clk) begin
    int idx;
    exp_t e;
    if (!rst_n) begin
      n_edge = 0;
      m_data = 32'h0;
      e.dig  = 8'hFF;
      e.sg   = 8'hFF;
      q.push_back(e);
    end else begin
      n_edge = n_edge + 1;
      idx    = int'(((n_edge - 1) / S) % 8);
      e.dig  = ~(8'd1 << idx);
      e.sg   = seg_tab[m_data[idx*4 +: 4]];
      q.push_back(e);
      if (we && addr == DA) m_data = wdata;
    end
  end

  // Monitor: compare each registered output shortly after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (dig_en !== e.dig || seg !== e.sg) begin
        errors++;
        $display("FAIL scan @%0t: dig_en=%h seg=%h, expected dig_en=%h seg=%h",
                 $time, dig_en, seg, e.dig, e.sg);
      end
      checks++;
      if ($countones(~dig_en) > 1) begin
        errors++;
        $display("FAIL onehot @%0t: dig_en=%h has more than one low bit", $time, dig_en);
      end
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Apply inputs for the next rising edge, return at the following negedge.
  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
    we    = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
  endtask

  // Assert reset between edges (with a write attempt), check, then release.
  task automatic do_reset(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    check8({name, "_rst_dig"}, dig_en, 8'hFF);
    check8({name, "_rst_seg"}, seg, 8'hFF);
    we    = 1'b1;
    addr  = DA;
    wdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    we    = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 32'h0, 32'h0);
    check8({name, "_first_dig"}, dig_en, 8'hFE);
    check8({name, "_first_seg"}, seg, 8'hC0);
  endtask

  initial begin
    logic [31:0] r;
    #1 rst_n = 1'b0;
    #1;
    check8("por_dig", dig_en, 8'hFF);
    check8("por_seg", seg, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan for two full periods.
    repeat (16 * S + 2) step(1'b0, 32'h0, 32'h0);

    // Full-word write, then a complete scan.
    step(1'b1, DA, 32'h89AB_CDEF);
    repeat (8 * S + 4) step(1'b0, 32'h0, 32'h0);

    // Write to the wrong address after reset: display stays zero.
    do_reset("badaddr");
    step(1'b1, 32'hFFFF_F004, 32'h1234_5678);
    repeat (8 * S + 2) step(1'b0, 32'h0, 32'h0);

    // Write on the edge where the index wraps from 7 back to 0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8 * S - 1) step(1'b0, 32'h0, 32'h0);
    step(1'b1, DA, 32'h0000_0001);
    step(1'b0, 32'h0, 32'h0);
    check8("wrapwr_dig", dig_en, 8'hFE);
    check8("wrapwr_seg", seg, 8'hF9);

    // Mid-scan reset while digit 5 is lit.
    step(1'b1, DA, 32'h7654_3210);
    repeat (5 * S) step(1'b0, 32'h0, 32'h0);
    check8("pre_mid_dig", dig_en, 8'hDF);
    do_reset("midscan");

    // Random write/idle traffic.
    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      step(1'b1, DA, $urandom);
      else if (r < 3) step(1'b1, DA ^ (32'h1 << $urandom_range(0, 31)), $urandom);
      else            step(1'b0, $urandom, $urandom);
    end
    step(1'b0, 32'h0, 32'h0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
